// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath widths, reset vector and the
// fetch-entry record handed from fetch to decode.
package mips_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [ADDR_W-1:0] pc_plus4(input logic [ADDR_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, inst} entries; flush empties
// it in one cycle without touching the storage.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = $bits(fetch_entry_t)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = push & ~flush;
    assign w_do_pop  = pop & ~flush;

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge Clk) begin
        if (Reset || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; an entry is only observable once the count
    // says it was written, so clearing the array would buy nothing.
    always_ff @(posedge Clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wdata;
    end

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, addresses the instruction ROM and
// queues fetched words for decode; execute redirects flush the queue.
module inst_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int                DEPTH    = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              FetchEn,
    output logic [ADDR_W-1:0] ImemAddr,
    input  logic [INST_W-1:0] ImemInst,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] RedirectPC,
    output logic              InstValid,
    output logic [INST_W-1:0] Inst,
    output logic [ADDR_W-1:0] InstPC,
    input  logic              InstReady
);

    logic [ADDR_W-1:0] r_pc;

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [ADDR_W-1:0] w_redirect_target;
    fetch_entry_t      w_wr_entry;
    fetch_entry_t      w_head;

    assign w_redirect_target = RedirectPC & 32'hFFFF_FFFC;

    assign InstValid = ~w_empty;
    assign w_pop     = InstValid & InstReady;
    // A pop frees a slot in the same cycle, so a full queue keeps streaming.
    assign w_push    = FetchEn & ~Redirect & (~w_full | w_pop);

    assign w_wr_entry = '{pc: r_pc, inst: ImemInst};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pc <= RESET_PC;
        end else if (Redirect) begin
            r_pc <= w_redirect_target;
        end else if (w_push) begin
            r_pc <= pc_plus4(r_pc);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (Redirect),
        .wdata (w_wr_entry),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

    assign ImemAddr = r_pc;
    assign Inst     = w_head.inst;
    assign InstPC   = w_head.pc;

endmodule
